// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: one free-running 16x baud tick shared by a transmitter
// and a receiver that run independently of each other.
module uart_core #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  input  logic       rx
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [CW-1:0] div_q, div_d;
  logic          tick;

  state_e      tx_state_q, tx_state_d;
  logic [3:0]  tx_tcnt_q, tx_tcnt_d;
  logic [2:0]  tx_bcnt_q, tx_bcnt_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d, tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;
  logic        tx_bit_end;

  logic        rx_meta_q, rx_sync_q;
  state_e      rx_state_q, rx_state_d;
  logic [3:0]  rx_tcnt_q, rx_tcnt_d;
  logic [2:0]  rx_bcnt_q, rx_bcnt_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_done_q, rx_done_d;
  logic        rx_mid, rx_bit_end;

  // Oversampling tick: one cycle each time the divider wraps.
  always_comb begin
    tick  = (div_q == CW'(DIV - 1));
    div_d = tick ? '0 : div_q + CW'(1);
  end

  // State registers for both halves and the rx synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // TX next state; the 4-bit tick counter wraps to zero at each bit boundary.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_end = tick && (tx_tcnt_q == 4'd15);
    if (tick && (tx_state_q != S_IDLE)) tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_state_q)
      S_IDLE: if (start) begin
        tx_sh_d    = tx_data;
        tx_tcnt_d  = '0;
        tx_bcnt_d  = '0;
        tx_state_d = S_START;
      end
      S_START: if (tx_bit_end) tx_state_d = S_DATA;
      S_DATA: if (tx_bit_end) begin
        if (tx_bcnt_q == 3'd7) begin
          tx_state_d = S_STOP;
        end else begin
          tx_sh_d   = {1'b0, tx_sh_q[7:1]};
          tx_bcnt_d = tx_bcnt_q + 3'd1;
        end
      end
      S_STOP: if (tx_bit_end) tx_state_d = S_IDLE;
      default: tx_state_d = S_IDLE;
    endcase
  end

  // TX outputs are computed from the next state so they register in step with it.
  always_comb begin
    tx_busy_d = (tx_state_d != S_IDLE);
    tx_done_d = (tx_state_q == S_STOP) && tx_bit_end;
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // RX next state: qualify the start bit at its centre, then sample every 16 ticks.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_sh_d    = rx_sh_q;
    rx_mid     = tick && (rx_tcnt_q == 4'd7);
    rx_bit_end = tick && (rx_tcnt_q == 4'd15);
    if (tick && (rx_state_q != S_IDLE)) rx_tcnt_d = rx_tcnt_q + 4'd1;
    case (rx_state_q)
      S_IDLE: if (!rx_sync_q) begin
        rx_tcnt_d  = '0;
        rx_state_d = S_START;
      end
      S_START: if (rx_mid) begin
        if (!rx_sync_q) begin
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_state_d = S_DATA;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_DATA: if (rx_bit_end) begin
        rx_sh_d = {rx_sync_q, rx_sh_q[7:1]};
        if (rx_bcnt_q == 3'd7) rx_state_d = S_STOP;
        else                   rx_bcnt_d  = rx_bcnt_q + 3'd1;
      end
      S_STOP: if (rx_bit_end) rx_state_d = S_IDLE;
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A byte is delivered only when the stop bit samples high.
  always_comb begin
    rx_done_d = (rx_state_q == S_STOP) && rx_bit_end && rx_sync_q;
    rx_data_d = rx_done_d ? rx_sh_q : rx_data_q;
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;
  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: loopback and pin-driven frames checked against an ideal
// 8N1 line model (bit-centre sampling, expected byte list).
module tb_uart_core;

  localparam int unsigned CLK_FREQ  = 100_000_000;
  localparam int unsigned BAUD_RATE = 1_562_500;
  localparam int D   = int'(CLK_FREQ / (BAUD_RATE * 16));
  localparam int BIT = 16 * D;

  logic       clk = 1'b0;
  logic       reset, start, tx_busy, tx_done, tx, rx_done, rx, rx_drv, loop;
  logic [7:0] tx_data, rx_data;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rx_q[$];
  int         rx_rd = 0;
  int         tx_done_cnt = 0;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx),
    .rx_data(rx_data), .rx_done(rx_done), .rx(rx)
  );

  // Every cycle rx_done is high logs one delivered byte.
  always @(negedge clk) begin
    if (rx_done === 1'b1) rx_q.push_back(rx_data);
    if (tx_done === 1'b1) tx_done_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; tx_data = 8'h00; loop = 1'b1; rx_drv = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_checks++; if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_checks++; if (rx_done !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_done got %b want 0", rx_done); end
    @(posedge clk); #2 reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Loopback one byte: check each bit at its ideal centre, frame length,
  // busy/done behaviour and the byte seen by the receiver.
  task automatic send_frame(input logic [7:0] b, input bit poke_busy);
    logic [9:0] frame;
    int n, done_n;
    bit busy_ok;
    frame = {1'b1, b, 1'b0};
    rx_rd = rx_q.size();
    @(negedge clk); tx_data = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; tx_data = 8'($urandom);
    n_checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++; $display("FAIL accept tx=%b busy=%b want tx=0 busy=1", tx, tx_busy);
    end
    n = 0; done_n = -1; busy_ok = 1'b1;
    while (done_n < 0 && n < 170 * D) begin
      @(posedge clk); #1 n++;
      if (poke_busy) begin
        if (n == 3 * BIT) begin start = 1'b1; tx_data = 8'h12; end
        else start = 1'b0;
      end
      if (tx_done === 1'b1) done_n = n;
      else if (tx_busy !== 1'b1) busy_ok = 1'b0;
      if ((n % BIT) == 7 * D && (n / BIT) <= 9) begin
        n_checks++;
        if (tx !== frame[n / BIT]) begin
          n_fail++; $display("FAIL tx_bit byte=%h bit=%0d got %b want %b", b, n / BIT, tx, frame[n / BIT]);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (done_n < 0) begin
      n_fail++; $display("FAIL tx_done_timeout byte=%h no tx_done within %0d cycles", b, 170 * D);
    end else if (done_n < 159 * D + 1 || done_n > 160 * D) begin
      n_fail++; $display("FAIL frame_len byte=%h got %0d want %0d..%0d", b, done_n, 159 * D + 1, 160 * D);
    end
    n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL busy_early byte=%h got drop want high", b); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got %b want 0", tx_busy); end
    @(posedge clk); #1;
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL done_width got %b want 0", tx_done); end
    n_checks++;
    if (rx_q.size() !== rx_rd + 1) begin
      n_fail++; $display("FAIL rx_count byte=%h got %0d want 1", b, rx_q.size() - rx_rd);
    end else if (rx_q[rx_rd] !== b || rx_data !== b) begin
      n_fail++; $display("FAIL rx_byte got %h want %h", rx_q[rx_rd], b);
    end
    rx_rd = rx_q.size();
  endtask

  task automatic test_loopback_ca();
    send_frame(8'hCA, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_frame(8'h55, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int td0;
    td0 = tx_done_cnt;
    send_frame(8'hCA, 1'b1);
    repeat (2 * BIT) @(posedge clk); #1;
    n_checks++;
    if (tx_done_cnt !== td0 + 1 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore got %0d frames busy=%b want 1 frame busy=0", tx_done_cnt - td0, tx_busy);
    end
  endtask

  // Drive one frame onto rx; a bad stop bit is low for 12 ticks then idles high.
  task automatic drive_rx(input logic [7:0] b, input bit good_stop);
    logic [9:0] f;
    f = {good_stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 rx_drv = f[k];
      repeat ((k == 9 && !good_stop) ? 12 * D - 1 : BIT - 1) @(posedge clk);
    end
    @(posedge clk); #1 rx_drv = 1'b1;
    repeat (3 * BIT) @(posedge clk);
  endtask

  task automatic test_rx_robust();
    int base;
    logic [7:0] v;
    loop = 1'b0; rx_drv = 1'b1;
    repeat (BIT) @(posedge clk);
    base = rx_q.size();
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (4 * D) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (3 * BIT) @(posedge clk); #1;
    n_checks++;
    if (rx_q.size() !== base) begin n_fail++; $display("FAIL glitch got %0d bytes want 0", rx_q.size() - base); end
    v = 8'($urandom);
    drive_rx(v, 1'b1);
    #1;
    n_checks++;
    if (rx_q.size() !== base + 1 || rx_data !== v) begin
      n_fail++; $display("FAIL rx_pin got %0d bytes data %h want 1 byte %h", rx_q.size() - base, rx_data, v);
    end
    drive_rx(~v, 1'b0);
    #1;
    n_checks++;
    if (rx_q.size() !== base + 1) begin n_fail++; $display("FAIL framing got %0d bytes want 1", rx_q.size() - base); end
    n_checks++;
    if (rx_data !== v) begin n_fail++; $display("FAIL framing_hold got %h want %h", rx_data, v); end
    rx_rd = rx_q.size();
    loop = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int td0, rq0;
    @(negedge clk); tx_data = 8'h3C; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4 * BIT + 8 * D) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    td0 = tx_done_cnt; rq0 = rx_q.size();
    n_checks++; if (tx !== 1'b1)      begin n_fail++; $display("FAIL midrst_tx got %b want 1", tx); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", tx_busy); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data got %h want 00", rx_data); end
    @(posedge clk); #2 reset = 1'b0;
    repeat (12 * BIT) @(posedge clk); #1;
    n_checks++;
    if (tx_done_cnt !== td0 || rx_q.size() !== rq0 || tx !== 1'b1) begin
      n_fail++; $display("FAIL midrst_quiet got tx_done=%0d rx_done=%0d tx=%b want 0 0 1",
                         tx_done_cnt - td0, rx_q.size() - rq0, tx);
    end
    send_frame(8'hA5, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) send_frame(8'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_loopback_ca();
    test_back_to_back();
    test_start_while_busy();
    test_rx_robust();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
